// File: rtl/display_scan_mux.sv
// Self-scanning multi-digit display multiplexer with active-low digit select,
// per-digit blanking and a frame-synchronous shadow buffer for the digit codes.
module display_scan_mux #(
  parameter int unsigned       N_DIGITS    = 8,
  parameter int unsigned       DATA_W      = 5,
  parameter int unsigned       DIV         = 50000,
  parameter logic [DATA_W-1:0] BLANK_CODE  = DATA_W'(5'h1F),
  parameter bit                SYNC_UPDATE = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_DIGITS*DATA_W-1:0]   data_bus,
  input  logic [N_DIGITS-1:0]          digit_en,
  input  logic                         update_req,
  output logic [N_DIGITS-1:0]          sel,
  output logic [DATA_W-1:0]            dataout,
  output logic                         frame_start,
  output logic                         busy
);

  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BUS_W = N_DIGITS * DATA_W;

  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [BUS_W-1:0]    r_shadow;
  logic                r_pending;
  logic [N_DIGITS-1:0] r_sel;
  logic [DATA_W-1:0]   r_dataout;
  logic                r_frame_start;

  logic                w_tick;
  logic                w_wrap;
  logic                w_load;
  logic                w_pending_next;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [IDX_W-1:0]    w_idx_next;
  logic [BUS_W-1:0]    w_shadow_next;
  logic                w_en;
  logic [DATA_W-1:0]   w_code;
  logic [N_DIGITS-1:0] w_sel_next;
  logic [DATA_W-1:0]   w_dataout_next;

  // Prescaler and scan index
  always_comb begin
    w_tick     = (r_cnt == CNT_W'(DIV - 1));
    w_wrap     = w_tick && (r_idx == IDX_W'(N_DIGITS - 1));
    w_cnt_next = w_tick ? '0 : r_cnt + CNT_W'(1);
    w_idx_next = r_idx;
    if (w_wrap) begin
      w_idx_next = '0;
    end else if (w_tick) begin
      w_idx_next = r_idx + IDX_W'(1);
    end
  end

  // Shadow load; a request coincident with the wrap is honoured at that wrap
  always_comb begin
    w_load         = 1'b1;
    w_pending_next = 1'b0;
    if (SYNC_UPDATE) begin
      w_load         = w_wrap && (r_pending || update_req);
      w_pending_next = !w_load && (r_pending || update_req);
    end
    w_shadow_next = w_load ? data_bus : r_shadow;
  end

  // Outputs are computed for the index being entered, from the bypassed shadow
  always_comb begin
    w_en   = 1'b0;
    w_code = '0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (w_idx_next == IDX_W'(k)) begin
        w_en   = digit_en[k];
        w_code = w_shadow_next[k*DATA_W +: DATA_W];
      end
    end
    w_sel_next     = '1;
    if (w_en) begin
      w_sel_next = ~(N_DIGITS'(1) << w_idx_next);
    end
    w_dataout_next = w_en ? w_code : BLANK_CODE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_shadow      <= '0;
      r_pending     <= 1'b0;
      r_sel         <= ~(N_DIGITS'(1));
      r_dataout     <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_next;
      r_idx         <= w_idx_next;
      r_shadow      <= w_shadow_next;
      r_pending     <= w_pending_next;
      r_sel         <= w_sel_next;
      r_dataout     <= w_dataout_next;
      r_frame_start <= w_wrap;
    end
  end

  assign sel         = r_sel;
  assign dataout     = r_dataout;
  assign frame_start = r_frame_start;
  assign busy        = r_pending;

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: a DIV=4 synchronous-update instance and a DIV=1
// free-running instance, checked against a cycle-count reference model.
module tb_display_scan_mux;

  localparam int ND = 4;
  localparam int DW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [19:0]   data_bus;
  logic [3:0]    digit_en;
  logic          update_req;
  logic [3:0]    s0, s1;
  logic [4:0]    d0, d1;
  logic          f0, f1, b0, b1;

  int n_pass  = 0;
  int n_total = 0;

  display_scan_mux #(.N_DIGITS(ND), .DATA_W(DW), .DIV(4), .BLANK_CODE(5'h1F), .SYNC_UPDATE(1'b1)) u_dut (
    .clk(clk), .rst(rst), .data_bus(data_bus), .digit_en(digit_en), .update_req(update_req),
    .sel(s0), .dataout(d0), .frame_start(f0), .busy(b0));

  display_scan_mux #(.N_DIGITS(ND), .DATA_W(DW), .DIV(1), .BLANK_CODE(5'h1F), .SYNC_UPDATE(1'b0)) u_fast (
    .clk(clk), .rst(rst), .data_bus(data_bus), .digit_en(digit_en), .update_req(update_req),
    .sel(s1), .dataout(d1), .frame_start(f1), .busy(b1));

  always #5 clk = ~clk;

  // Reference model state, one slot per instance
  int         m_div  [2] = '{4, 1};
  bit         m_sync [2] = '{1'b1, 1'b0};
  int         m_t    [2];
  logic [4:0] m_shadow [2][4];
  bit         m_pend [2];
  logic [3:0] x_sel  [2];
  logic [4:0] x_dout [2];
  bit         x_fs   [2];
  bit         x_busy [2];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: position in the frame follows from the number of edges since reset
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_t[i] = 0;
        for (int d = 0; d < 4; d++) m_shadow[i][d] = '0;
        m_pend[i] = 1'b0;
        x_sel[i]  = 4'b1110;
        x_dout[i] = 5'h00;
        x_fs[i]   = 1'b0;
        x_busy[i] = 1'b0;
      end else begin
        int  t1, idx;
        bit  wrap, load;
        t1   = m_t[i] + 1;
        idx  = (t1 / m_div[i]) % ND;
        wrap = (t1 % (ND * m_div[i])) == 0;
        load = m_sync[i] ? (wrap && (m_pend[i] || update_req)) : 1'b1;
        if (load)
          for (int d = 0; d < 4; d++) m_shadow[i][d] = data_bus[d*DW +: DW];
        m_pend[i] = m_sync[i] && !load && (m_pend[i] || update_req);
        x_sel[i] = 4'hF;
        if (digit_en[idx]) x_sel[i][idx] = 1'b0;
        x_dout[i] = digit_en[idx] ? m_shadow[i][idx] : 5'h1F;
        x_fs[i]   = wrap;
        x_busy[i] = m_pend[i];
        m_t[i]    = t1 % (ND * m_div[i]);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("sel",          int'(s0), int'(x_sel[0]));
    chk("dataout",      int'(d0), int'(x_dout[0]));
    chk("frame_start",  int'(f0), int'(x_fs[0]));
    chk("busy",         int'(b0), int'(x_busy[0]));
    chk("fast_sel",     int'(s1), int'(x_sel[1]));
    chk("fast_dataout", int'(d1), int'(x_dout[1]));
    chk("fast_fs",      int'(f1), int'(x_fs[1]));
    chk("fast_busy",    int'(b1), int'(x_busy[1]));
  endtask

  typedef struct {
    bit         rst;
    bit         req;
    logic [3:0] sel;
    logic [4:0] dout;
    bit         fs;
    bit         busy;
  } vec_t;

  vec_t tbl[22];

  initial begin
    logic [19:0] prev;
    logic [3:0]  fsel [4];
    int          cnt_blank, cnt_fs, cnt_dark;

    // Reset, first frame and a deferred update requested at cycle 5
    tbl[0]  = '{1'b1, 1'b0, 4'b1110, 5'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'b1110, 5'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'b1110, 5'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'b1110, 5'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'b1110, 5'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'b1101, 5'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 4'b1101, 5'd0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 4'b1101, 5'd0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 4'b1101, 5'd0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 4'b1011, 5'd0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 4'b1011, 5'd0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 4'b1011, 5'd0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 4'b1011, 5'd0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 4'b0111, 5'd0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 4'b0111, 5'd0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 4'b0111, 5'd0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 4'b0111, 5'd0, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 4'b1110, 5'd1, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 4'b1110, 5'd1, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 4'b1110, 5'd1, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 4'b1110, 5'd1, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 4'b1101, 5'd2, 1'b0, 1'b0};

    rst = 1'b1; update_req = 1'b0; digit_en = 4'hF;
    data_bus = {5'd4, 5'd3, 5'd2, 5'd1};
    for (int i = 0; i < 22; i++) begin
      rst = tbl[i].rst; update_req = tbl[i].req;
      tick();
      chk("tbl_sel",  int'(s0), int'(tbl[i].sel));
      chk("tbl_dout", int'(d0), int'(tbl[i].dout));
      chk("tbl_fs",   int'(f0), int'(tbl[i].fs));
      chk("tbl_busy", int'(b0), int'(tbl[i].busy));
    end
    update_req = 1'b0;

    // Blanking of digit 2: still dwells the full four cycles
    digit_en = 4'b1011; cnt_blank = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (s0 == 4'hF && d0 == 5'h1F) cnt_blank++;
    end
    chk("blank_dwell", cnt_blank, 4);

    // All digits blanked: select stays dark, frames keep coming
    digit_en = 4'h0; cnt_fs = 0; cnt_dark = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (f0) cnt_fs++;
      if (s0 == 4'hF) cnt_dark++;
    end
    chk("dark_fs", cnt_fs, 1);
    chk("dark_sel", cnt_dark, 16);
    digit_en = 4'hF;

    // Request on the wrap cycle is applied at that edge
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("pre_wrap_busy", int'(b0), 0);
    chk("pre_wrap_sel", int'(s0), 4'b0111);
    data_bus = {5'd9, 5'd8, 5'd7, 5'd6}; update_req = 1'b1;
    tick();
    update_req = 1'b0;
    chk("coinc_dout", int'(d0), 6);
    chk("coinc_busy", int'(b0), 0);
    chk("coinc_fs", int'(f0), 1);

    // Reset mid-scan drops the pending request
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    data_bus = {5'd13, 5'd12, 5'd11, 5'd10};
    for (int i = 0; i < 5; i++) tick();
    update_req = 1'b1; tick(); update_req = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("mid_busy_before", int'(b0), 1);
    chk("mid_sel_before", int'(s0), 4'b1011);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_sel", int'(s0), 4'b1110);
    chk("mid_rst_busy", int'(b0), 0);
    chk("mid_rst_dout", int'(d0), 0);
    for (int i = 0; i < 16; i++) tick();
    chk("mid_after_fs", int'(f0), 1);
    chk("mid_after_dout", int'(d0), 0);

    // DIV=1, free-running shadow: rotate every cycle, one cycle of latency
    fsel = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      data_bus = 20'($urandom);
      prev = data_bus;
      tick();
      chk("fast_rot_sel", int'(s1), int'(fsel[k-1]));
      chk("fast_rot_dout", int'(d1), int'(prev[(k % 4)*DW +: DW]));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      data_bus   = 20'($urandom);
      update_req = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) digit_en = 4'($urandom);
      rst        = ($urandom_range(0, 149) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
